// File: rtl/mfcc_feature_store.sv
// MFCC feature memory: frame-by-frame coefficient writes, registered random reads, sequential clear.
// Define FEATURE_STORE_WRAP_EN to overwrite the oldest frames instead of stopping when full (adds overflow).
module mfcc_feature_store #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned NUM_COEF   = 26,
   parameter int unsigned MAX_FRAMES = 256,
   parameter int unsigned FRAME_W    = 8,
   parameter int unsigned COEF_W     = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr_start,
   input  logic               wr_valid,
   input  logic [DATA_W-1:0]  wr_data,
   output logic               wr_ready,
   input  logic               rd_req,
   input  logic [FRAME_W-1:0] rd_frame,
   input  logic [COEF_W-1:0]  rd_coef,
   output logic [DATA_W-1:0]  rd_data,
   output logic               rd_valid,
   output logic [FRAME_W:0]   frame_count,
   output logic               frame_done,
   output logic               full,
`ifdef FEATURE_STORE_WRAP_EN
   output logic               overflow,
`endif
   output logic               busy
);

   localparam int unsigned DEPTH  = MAX_FRAMES * NUM_COEF;
   localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = FRAME_W + 1;
   localparam int unsigned CIDX_W = COEF_W + 1;

   typedef enum logic [1:0] {
      S_CLEAR,
      S_RUN
`ifndef FEATURE_STORE_WRAP_EN
      , S_FULL
`endif
   } state_t;

   state_t state, state_next;

   logic [DATA_W-1:0]  mem [DEPTH];

   logic [ADDR_W-1:0]  clr_ptr, clr_ptr_d;
   logic [FRAME_W-1:0] wr_frame, wr_frame_d;
   logic [COEF_W-1:0]  wr_coef, wr_coef_d;
   logic [CNT_W-1:0]   frame_count_d;
   logic               frame_done_d, full_d, busy_d, wr_ready_d;
`ifdef FEATURE_STORE_WRAP_EN
   logic               overflow_d;
`endif

   logic               mem_we_c;
   logic [ADDR_W-1:0]  mem_waddr_c;
   logic [DATA_W-1:0]  mem_wdata_c;

   logic               clr_last_c, clr_req_c, wr_acc_c, coef_last_c, frame_last_c, frame_end_c;
   logic               rd_en_c, rd_ok_c;
   logic [ADDR_W-1:0]  wr_addr_c, rd_addr_c;

   assign clr_last_c   = (clr_ptr == ADDR_W'(DEPTH - 1));
   assign clr_req_c    = clr_start && (state != S_CLEAR);
   assign wr_acc_c     = wr_valid && wr_ready && !clr_req_c;
   assign coef_last_c  = (wr_coef == COEF_W'(NUM_COEF - 1));
   assign frame_last_c = (wr_frame == FRAME_W'(MAX_FRAMES - 1));
   assign frame_end_c  = wr_acc_c && coef_last_c;
   assign wr_addr_c    = ADDR_W'(wr_frame) * ADDR_W'(NUM_COEF) + ADDR_W'(wr_coef);

   // Out-of-range indices still produce a read pulse, just with zero data.
   assign rd_en_c   = rd_req && (state != S_CLEAR);
   assign rd_ok_c   = ({1'b0, rd_frame} < CNT_W'(MAX_FRAMES)) && ({1'b0, rd_coef} < CIDX_W'(NUM_COEF));
   assign rd_addr_c = ADDR_W'(rd_frame) * ADDR_W'(NUM_COEF) + ADDR_W'(rd_coef);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_CLEAR;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_CLEAR: if (clr_last_c) state_next = S_RUN;
         S_RUN: begin
            if (clr_req_c) state_next = S_CLEAR;
`ifndef FEATURE_STORE_WRAP_EN
            else if (frame_end_c && (frame_count == CNT_W'(MAX_FRAMES - 1))) state_next = S_FULL;
`endif
         end
`ifndef FEATURE_STORE_WRAP_EN
         S_FULL: if (clr_req_c) state_next = S_CLEAR;
`endif
         default: state_next = S_CLEAR;
      endcase
   end

   // Next values for pointers, bookkeeping and the single memory write port.
   always_comb begin
      mem_we_c      = 1'b0;
      mem_waddr_c   = clr_ptr;
      mem_wdata_c   = '0;
      clr_ptr_d     = clr_ptr;
      wr_frame_d    = wr_frame;
      wr_coef_d     = wr_coef;
      frame_count_d = frame_count;
      frame_done_d  = 1'b0;
      full_d        = full;
`ifdef FEATURE_STORE_WRAP_EN
      overflow_d    = overflow;
`endif
      if (state == S_CLEAR) begin
         mem_we_c  = 1'b1;
         clr_ptr_d = clr_last_c ? '0 : clr_ptr + 1'b1;
      end else if (clr_req_c) begin
         clr_ptr_d     = '0;
         wr_frame_d    = '0;
         wr_coef_d     = '0;
         frame_count_d = '0;
         full_d        = 1'b0;
`ifdef FEATURE_STORE_WRAP_EN
         overflow_d    = 1'b0;
`endif
      end else if (wr_acc_c) begin
         mem_we_c    = 1'b1;
         mem_waddr_c = wr_addr_c;
         mem_wdata_c = wr_data;
         if (coef_last_c) begin
            wr_coef_d    = '0;
            wr_frame_d   = frame_last_c ? '0 : wr_frame + 1'b1;
            frame_done_d = 1'b1;
            if (frame_count != CNT_W'(MAX_FRAMES)) frame_count_d = frame_count + 1'b1;
            full_d = (frame_count_d == CNT_W'(MAX_FRAMES));
`ifdef FEATURE_STORE_WRAP_EN
            if (frame_last_c) overflow_d = 1'b1;
`endif
         end else begin
            wr_coef_d = wr_coef + 1'b1;
         end
      end
      busy_d     = (state_next == S_CLEAR);
      wr_ready_d = (state_next == S_RUN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clr_ptr     <= '0;
         wr_frame    <= '0;
         wr_coef     <= '0;
         frame_count <= '0;
         frame_done  <= 1'b0;
         full        <= 1'b0;
         busy        <= 1'b1;
         wr_ready    <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
`ifdef FEATURE_STORE_WRAP_EN
         overflow    <= 1'b0;
`endif
      end else begin
         clr_ptr     <= clr_ptr_d;
         wr_frame    <= wr_frame_d;
         wr_coef     <= wr_coef_d;
         frame_count <= frame_count_d;
         frame_done  <= frame_done_d;
         full        <= full_d;
         busy        <= busy_d;
         wr_ready    <= wr_ready_d;
         rd_valid    <= rd_en_c;
         if (rd_en_c) rd_data <= rd_ok_c ? mem[rd_addr_c] : '0;
`ifdef FEATURE_STORE_WRAP_EN
         overflow    <= overflow_d;
`endif
      end
   end

   // Storage array has no reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
   end

endmodule

// File: tb/tb_mfcc_feature_store.sv
// Self-checking bench for mfcc_feature_store (4 frames x 26 coefficients); honours FEATURE_STORE_WRAP_EN.
module tb_mfcc_feature_store;

   localparam int NC    = 26;
   localparam int MF    = 4;
   localparam int DEPTH = NC * MF;
`ifdef FEATURE_STORE_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clr_start = 1'b0;
   logic        wr_valid = 1'b0;
   logic [15:0] wr_data = '0;
   logic        wr_ready;
   logic        rd_req = 1'b0;
   logic [2:0]  rd_frame = '0;
   logic [4:0]  rd_coef = '0;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic [3:0]  frame_count;
   logic        frame_done;
   logic        full;
   logic        busy;
`ifdef FEATURE_STORE_WRAP_EN
   logic        overflow;
`endif

   mfcc_feature_store #(
      .DATA_W(16), .NUM_COEF(NC), .MAX_FRAMES(MF), .FRAME_W(3), .COEF_W(5)
   ) dut (
      .clk(clk), .reset(reset), .clr_start(clr_start),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_req(rd_req), .rd_frame(rd_frame), .rd_coef(rd_coef),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .frame_count(frame_count), .frame_done(frame_done), .full(full),
`ifdef FEATURE_STORE_WRAP_EN
      .overflow(overflow),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Reference model: flat word count since the last clear decides everything.
   logic [15:0] mem_m [MF][NC];
   int          n_words;
   int          clr_left;
   logic [15:0] last_rd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic zero_model();
      for (int f = 0; f < MF; f++)
         for (int c = 0; c < NC; c++) mem_m[f][c] = 16'h0;
   endtask

   task automatic check_outputs(input bit exp_done);
      int fc;
      fc = n_words / NC;
      if (fc > MF) fc = MF;
      check("rd_data", 32'(rd_data), 32'(last_rd));
      check("frame_done", 32'(frame_done), 32'(exp_done));
      check("frame_count", 32'(frame_count), 32'(fc));
      check("full", 32'(full), 32'(n_words >= DEPTH));
      check("busy", 32'(busy), 32'(clr_left > 0));
      check("wr_ready", 32'(wr_ready), 32'(clr_left == 0 && (WRAP || n_words < DEPTH)));
`ifdef FEATURE_STORE_WRAP_EN
      check("overflow", 32'(overflow), 32'(n_words >= DEPTH));
`endif
   endtask

   // One clock: apply inputs, predict, advance, compare every output.
   task automatic cycle(input bit wv, input logic [15:0] wd, input bit rq,
                        input int rf, input int rc, input bit cs);
      bit          busy_m, clr_go, acc, rv;
      logic [15:0] rexp;
      busy_m = (clr_left > 0);
      clr_go = cs && !busy_m;
      acc    = wv && !busy_m && !clr_go && (WRAP || n_words < DEPTH);
      rv     = rq && !busy_m;
      rexp   = 16'h0;
      if (rf < MF && rc < NC) rexp = mem_m[rf][rc];
      wr_valid = wv; wr_data = wd; rd_req = rq;
      rd_frame = 3'(rf); rd_coef = 5'(rc); clr_start = cs;
      @(posedge clk); #1;
      wr_valid = 1'b0; rd_req = 1'b0; clr_start = 1'b0;
      if (busy_m) clr_left--;
      if (clr_go) begin
         clr_left = DEPTH;
         n_words  = 0;
         zero_model();
      end
      if (acc) begin
         mem_m[(n_words / NC) % MF][n_words % NC] = wd;
         n_words++;
      end
      if (rv) last_rd = rexp;
      check("rd_valid", 32'(rd_valid), 32'(rv));
      check_outputs(acc && (n_words % NC == 0));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      wr_valid = 1'b0; rd_req = 1'b0; clr_start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      clr_left = DEPTH;
      n_words  = 0;
      last_rd  = 16'h0;
      zero_model();
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check_outputs(1'b0);
      reset = 1'b1;
   endtask

   task automatic rd(input int rf, input int rc);
      cycle(1'b0, 16'h0, 1'b1, rf, rc, 1'b0);
   endtask

   task automatic idle_busy(input int k);
      for (int i = 0; i < k; i++)
         cycle(1'($urandom % 2), 16'($urandom), 1'b1, int'($urandom_range(0, 7)),
               int'($urandom_range(0, 31)), i == k / 2);
   endtask

   initial begin
      // Reset, interrupt the sweep with a second reset, then let it complete.
      do_reset();
      idle_busy(20);
      do_reset();
      idle_busy(DEPTH);

      // Freshly cleared memory, including the last valid and out-of-range indices.
      rd(MF - 1, NC - 1);
      rd(7, 31);
      rd(MF, 0);
      rd(0, NC);

      // One frame with wr_valid held high.
      for (int i = 0; i < NC; i++) cycle(1'b1, 16'(16'h0100 + i), 1'b0, 0, 0, 1'b0);
      rd(0, 0);
      rd(0, NC - 1);

      // Two frames with wr_valid toggling.
      for (int i = 0; i < 4 * NC; i++) cycle(i % 2 == 0, 16'($urandom), 1'b0, 0, 0, 1'b0);
      rd(1, 3);
      for (int i = 0; i < 30; i++) rd(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));

      // Read and write the same address in one cycle, then read it back.
      cycle(1'b1, 16'hBEEF, 1'b1, 3, 0, 1'b0);
      rd(3, 0);

      // Fill to capacity, then push extra words.
      for (int i = n_words; i < DEPTH; i++) cycle(1'b1, 16'($urandom), 1'b0, 0, 0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 16'(16'hA000 + i), 1'b0, 0, 0, 1'b0);
      for (int f = 0; f < MF; f++)
         for (int c = 0; c < NC; c++) rd(f, c);

      // Clear from a full store, then clear again mid-frame with a write in the same cycle.
      cycle(1'b0, 16'h0, 1'b0, 0, 0, 1'b1);
      idle_busy(DEPTH);
      for (int i = 0; i < 10; i++) cycle(1'b1, 16'($urandom), 1'b0, 0, 0, 1'b0);
      cycle(1'b1, 16'hDEAD, 1'b0, 0, 0, 1'b1);
      idle_busy(DEPTH);
      rd(0, 0);
      rd(0, 9);

      // Randomised traffic with an occasional clear and one reset mid-frame.
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         cycle($urandom % 4 != 0, 16'($urandom), 1'($urandom % 2),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 31)), $urandom % 300 == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
